// File: rtl/gray_hblur3.sv
// Streaming 3-tap horizontal blur (1-2-1)/4 on gray pixels. Each line boundary replicates
// the edge pixel. The stage holds one pixel of look-ahead and drives a registered output.
module gray_hblur3 #(
  parameter int unsigned LEN_W = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [23:0]      pix_in,
  input  logic             in_valid,
  input  logic             in_sol,
  input  logic             in_eol,
  output logic             in_ready,
  output logic [23:0]      pix_out,
  output logic             out_valid,
  output logic             out_sol,
  output logic             out_eol,
  input  logic             out_ready,
  output logic [LEN_W-1:0] line_len,
  output logic             sync_err
);

  typedef enum logic [1:0] {StEmpty, StHave, StFlush} state_e;

  localparam logic [LEN_W-1:0] CntMax = '1;

  state_e           state_q, state_d;
  logic [7:0]       prev_q, prev_d, cur_q, cur_d;
  logic [LEN_W-1:0] cnt_q, cnt_d, len_d;
  logic             first_q, first_d, err_d;
  logic             load, accept, emit, emit_sol, emit_eol;
  logic [7:0]       emit_y, g;
  logic             unused_hi;

  assign unused_hi = ^pix_in[23:8];

  function automatic logic [7:0] blur(input logic [7:0] a, input logic [7:0] b,
                                      input logic [7:0] c);
    logic [9:0] sum;
    sum = {2'b00, a} + {1'b0, b, 1'b0} + {2'b00, c};
    return sum[9:2];
  endfunction

  always_comb begin
    g        = pix_in[7:0];
    load     = !out_valid || out_ready;
    in_ready = load && (state_q != StFlush);
    accept   = in_valid && in_ready;
    state_d  = state_q;
    prev_d   = prev_q;
    cur_d    = cur_q;
    cnt_d    = cnt_q;
    first_d  = first_q;
    err_d    = sync_err;
    len_d    = line_len;
    emit     = 1'b0;
    emit_y   = '0;
    emit_sol = 1'b0;
    emit_eol = 1'b0;
    case (state_q)
      StEmpty, StHave: begin
        if (accept) begin
          if (state_q == StEmpty || in_sol) begin
            // Missing sol still starts a line; a mid-line sol or a stray eol is a sync error.
            if (state_q == StHave || (in_eol && !in_sol)) err_d = 1'b1;
            prev_d  = g;
            cur_d   = g;
            cnt_d   = LEN_W'(1);
            first_d = 1'b1;
            state_d = in_eol ? StFlush : StHave;
          end else begin
            emit     = 1'b1;
            emit_y   = blur(prev_q, cur_q, g);
            emit_sol = first_q;
            prev_d   = cur_q;
            cur_d    = g;
            first_d  = 1'b0;
            if (cnt_q != CntMax) cnt_d = cnt_q + 1'b1;
            if (in_eol) state_d = StFlush;
          end
        end
      end
      StFlush: begin
        if (load) begin
          emit     = 1'b1;
          emit_y   = blur(prev_q, cur_q, cur_q);
          emit_sol = first_q;
          emit_eol = 1'b1;
          len_d    = cnt_q;
          state_d  = StEmpty;
        end
      end
      default: state_d = StEmpty;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StEmpty;
      prev_q    <= '0;
      cur_q     <= '0;
      cnt_q     <= '0;
      first_q   <= 1'b0;
      line_len  <= '0;
      sync_err  <= 1'b0;
      pix_out   <= '0;
      out_valid <= 1'b0;
      out_sol   <= 1'b0;
      out_eol   <= 1'b0;
    end else begin
      state_q  <= state_d;
      prev_q   <= prev_d;
      cur_q    <= cur_d;
      cnt_q    <= cnt_d;
      first_q  <= first_d;
      line_len <= len_d;
      sync_err <= err_d;
      if (load) begin
        out_valid <= emit;
        if (emit) begin
          pix_out <= {3{emit_y}};
          out_sol <= emit_sol;
          out_eol <= emit_eol;
        end
      end
    end
  end

endmodule

// File: tb/tb_gray_hblur3.sv
// Bench for gray_hblur3: line-level reference model plus directed and randomised lines.
module tb_gray_hblur3;

  localparam int unsigned LEN_W = 4;
  localparam int LEN_MAX = 15;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [23:0]      pix_in = '0;
  logic             in_valid = 1'b0, in_sol = 1'b0, in_eol = 1'b0, in_ready;
  logic [23:0]      pix_out;
  logic             out_valid, out_sol, out_eol;
  logic             out_ready = 1'b1;
  logic [LEN_W-1:0] line_len;
  logic             sync_err;

  gray_hblur3 #(.LEN_W(LEN_W)) dut (
    .clk(clk), .rst_n(rst_n), .pix_in(pix_in), .in_valid(in_valid), .in_sol(in_sol),
    .in_eol(in_eol), .in_ready(in_ready), .pix_out(pix_out), .out_valid(out_valid),
    .out_sol(out_sol), .out_eol(out_eol), .out_ready(out_ready), .line_len(line_len),
    .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] y;
    bit         sol;
    bit         eol;
    int         len;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        e;
  int          line_px[$];
  logic [23:0] got[$];
  bit          exp_err = 1'b0;
  bit          gap_en = 1'b0;
  int          bp_mode = 0;
  int          checks = 0, errors = 0;

  function automatic int blur3(int a, int b, int c);
    return (a + 2 * b + c) / 4;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  function automatic void push_exp(int y, bit sol, bit eol, int len);
    exp_t x;
    x.y = 8'(y);
    x.sol = sol;
    x.eol = eol;
    x.len = len;
    exp_q.push_back(x);
  endfunction

  // Line view: pixel x leaves once x+1 is known; the last pixel leaves at eol.
  function automatic void model_accept(int g, bit sol, bit eol);
    int n, left;
    if (line_px.size() == 0) begin
      if (eol && !sol) exp_err = 1'b1;
      line_px.push_back(g);
    end else if (sol) begin
      exp_err = 1'b1;
      line_px.delete();
      line_px.push_back(g);
    end else begin
      line_px.push_back(g);
      n = line_px.size();
      left = (n >= 3) ? line_px[n-3] : line_px[n-2];
      push_exp(blur3(left, line_px[n-2], g), n == 2, 1'b0, 0);
    end
    if (eol) begin
      n = line_px.size();
      left = (n >= 2) ? line_px[n-2] : line_px[n-1];
      push_exp(blur3(left, line_px[n-1], line_px[n-1]), n == 1, 1'b1,
               (n > LEN_MAX) ? LEN_MAX : n);
      line_px.delete();
    end
  endfunction

  task automatic send(input logic [7:0] g, input bit sol, input bit eol);
    bit ok;
    int n;
    ok = 1'b0;
    n = 0;
    pix_in = {16'($urandom), g};
    in_valid = 1'b1;
    in_sol = sol;
    in_eol = eol;
    while (!ok && n < 500) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      n++;
    end
    if (ok) model_accept(int'(g), sol, eol);
    else begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got in_ready=0, expected 1 within 500 cycles");
    end
    #1;
    in_valid = 1'b0;
    in_sol = 1'b0;
    in_eol = 1'b0;
  endtask

  task automatic send_line(input logic [7:0] px[$], input bit do_eol);
    for (int i = 0; i < px.size(); i++) begin
      send(px[i], i == 0, do_eol && (i == px.size() - 1));
      if (gap_en && $urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending outputs, expected 0", exp_q.size());
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_line1();
    check("l1_count", got.size(), 4);
    check("l1_px0", got[0], 24'h141414);
    check("l1_px1", got[1], 24'h202020);
    check("l1_px2", got[2], 24'h303030);
    check("l1_px3", got[3], 24'h3C3C3C);
    check("l1_len", line_len, 4);
    check("l1_err", sync_err, 0);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (bp_mode)
        0: out_ready = 1'b1;
        1: out_ready = ($urandom_range(0, 9) < 7);
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Compare process: output stream, hold-under-stall and sticky error.
  bit          stall = 1'b0;
  logic [25:0] hold;
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) stall = 1'b0;
      else begin
        check("sync_err", sync_err, exp_err);
        if (stall) begin
          check("hold_valid", out_valid, 1);
          check("hold_data", {pix_out, out_sol, out_eol}, hold);
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL extra_output: got %06h, expected no output", pix_out);
          end else begin
            e = exp_q.pop_front();
            check("pix", pix_out, {3{e.y}});
            check("sol", out_sol, e.sol);
            check("eol", out_eol, e.eol);
            if (e.eol) check("line_len", line_len, e.len);
          end
          got.push_back(pix_out);
          stall = 1'b0;
        end else if (out_valid) begin
          stall = 1'b1;
          hold = {pix_out, out_sol, out_eol};
        end else stall = 1'b0;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish, expected end before 400000");
    $fatal(1);
  end

  initial begin
    logic [7:0] line[$];
    int n;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", out_valid, 0);
    check("rst_pix", pix_out, 0);
    check("rst_len", line_len, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", in_ready, 1);
    @(posedge clk);
    #1;

    got.delete();
    line = '{8'h10, 8'h20, 8'h30, 8'h40};
    send_line(line, 1'b1);
    drain();
    check_line1();

    got.delete();
    line = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    send_line(line, 1'b1);
    drain();
    check("ff_count", got.size(), 8);
    for (int i = 0; i < 8; i++) check("ff_px", got[i], 24'hFFFFFF);
    check("ff_len", line_len, 8);

    got.delete();
    send(8'h80, 1'b1, 1'b1);
    drain();
    check("single_px", got[0], 24'h808080);
    check("single_len", line_len, 1);
    check("single_err", sync_err, 0);

    got.delete();
    bp_mode = 2;
    @(posedge clk);
    #2;
    line = '{8'h00, 8'hFF, 8'h00};
    fork
      send_line(line, 1'b1);
      begin
        n = 0;
        while (!out_valid && n < 50) begin
          @(negedge clk);
          n++;
        end
        repeat (5) begin
          check("bp_valid", out_valid, 1);
          check("bp_pix", pix_out, 24'h3F3F3F);
          check("bp_ready", in_ready, 0);
          @(negedge clk);
        end
        bp_mode = 0;
      end
    join
    drain();
    check("bp_count", got.size(), 3);
    check("bp_px0", got[0], 24'h3F3F3F);
    check("bp_px1", got[1], 24'h7F7F7F);
    check("bp_px2", got[2], 24'h3F3F3F);

    got.delete();
    line = '{8'h10, 8'h20};
    send_line(line, 1'b0);
    line = '{8'h50, 8'h50};
    send_line(line, 1'b1);
    drain();
    check("abort_count", got.size(), 3);
    check("abort_px0", got[0], 24'h141414);
    check("abort_px1", got[1], 24'h505050);
    check("abort_px2", got[2], 24'h505050);
    check("abort_err", sync_err, 1);

    line = '{8'h10, 8'h20};
    send_line(line, 1'b0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    exp_err = 1'b0;
    exp_q.delete();
    line_px.delete();
    #1 check("async_valid", out_valid, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rerst_valid", out_valid, 0);
    check("rerst_len", line_len, 0);
    check("rerst_ready", in_ready, 1);
    @(posedge clk);
    #1;
    got.delete();
    line = '{8'h10, 8'h20, 8'h30, 8'h40};
    send_line(line, 1'b1);
    drain();
    check_line1();

    got.delete();
    send(8'h33, 1'b0, 1'b1);
    drain();
    check("stray_px", got[0], 24'h333333);
    check("stray_err", sync_err, 1);

    line.delete();
    for (int i = 0; i < 20; i++) line.push_back(8'($urandom));
    send_line(line, 1'b1);
    drain();
    check("sat_len", line_len, LEN_MAX);

    gap_en = 1'b1;
    for (int k = 0; k < 40; k++) begin
      bp_mode = $urandom_range(0, 1);
      if ($urandom_range(0, 7) == 0) begin
        line.delete();
        repeat ($urandom_range(1, 4)) line.push_back(8'($urandom));
        send_line(line, 1'b0);
      end
      line.delete();
      repeat ($urandom_range(1, 12)) line.push_back(8'($urandom));
      send_line(line, 1'b1);
    end
    bp_mode = 0;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
